// File: rtl/vend_pkg.sv
// Shared definitions for the change-dispensing path: denomination indices,
// coin values and the dispenser state encoding.
package vend_pkg;

  localparam int NUM_DEN     = 4;
  localparam int DEN_DOLLAR  = 3;
  localparam int DEN_QUARTER = 2;
  localparam int DEN_DIME    = 1;
  localparam int DEN_NICKEL  = 0;

  localparam logic [8:0] VAL_DOLLAR  = 9'd100;
  localparam logic [8:0] VAL_QUARTER = 9'd25;
  localparam logic [8:0] VAL_DIME    = 9'd10;
  localparam logic [8:0] VAL_NICKEL  = 9'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  function automatic logic [8:0] coin_value(input int idx);
    case (idx)
      DEN_DOLLAR:  return VAL_DOLLAR;
      DEN_QUARTER: return VAL_QUARTER;
      DEN_DIME:    return VAL_DIME;
      default:     return VAL_NICKEL;
    endcase
  endfunction

endpackage

// File: rtl/denom_select.sv
// Greedy coin pick: highest denomination that fits in owed and whose hopper
// is not reported empty. Purely combinational.
module denom_select
  import vend_pkg::*;
(
  input  logic [8:0] owed,
  input  logic [3:0] hopper_empty,
  output logic [3:0] onehot,
  output logic [8:0] value,
  output logic       valid
);

  always_comb begin
    onehot = '0;
    value  = '0;
    valid  = 1'b0;
    for (int i = NUM_DEN - 1; i >= 0; i--) begin
      if (!valid && !hopper_empty[i] && (owed >= coin_value(i))) begin
        onehot[i] = 1'b1;
        value     = coin_value(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out owed change one coin at a time over a req/ack hopper handshake,
// re-picking the denomination before every coin so empty hoppers are routed around.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int TIMER_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       change_dollar,
  input  logic [1:0] change_quarters,
  input  logic [3:0] change_dimes,
  input  logic [4:0] change_nickels,
  input  logic [3:0] hopper_empty,
  input  logic       hopper_ack,
  input  logic       clr,
  output logic [3:0] eject_req,
  output logic       ready,
  output logic       done,
  output logic       fault,
  output logic [8:0] owed,
  output logic [8:0] dispensed
);

  localparam logic [TIMER_W-1:0] TIMEOUT_CNT = TIMER_W'(ACK_TIMEOUT);
  localparam logic [TIMER_W-1:0] GAP_LAST    = TIMER_W'(GAP_CYCLES - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [8:0]         owed_q, disp_q, val_q;
  logic [3:0]         eject_q;
  logic [3:0]         sel_onehot;
  logic [8:0]         sel_value;
  logic               sel_valid;

  // Worst case 100 + 3*25 + 15*10 + 31*5 = 480, so 9 bits never wrap.
  function automatic logic [8:0] change_total(input logic       dl,
                                              input logic [1:0] qt,
                                              input logic [3:0] dm,
                                              input logic [4:0] nk);
    logic [8:0] sum;
    sum = dl ? VAL_DOLLAR : 9'd0;
    sum = sum + 9'(qt) * VAL_QUARTER;
    sum = sum + 9'(dm) * VAL_DIME;
    sum = sum + 9'(nk) * VAL_NICKEL;
    return sum;
  endfunction

  denom_select u_denom_select (
    .owed         (owed_q),
    .hopper_empty (hopper_empty),
    .onehot       (sel_onehot),
    .value        (sel_value),
    .valid        (sel_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_SELECT;
      ST_SELECT: begin
        if (owed_q == 9'd0)  state_d = ST_DONE;
        else if (sel_valid)  state_d = ST_EJECT;
        else                 state_d = ST_FAULT;
      end
      // A coin confirmed in the timeout cycle still counts as paid.
      ST_EJECT: begin
        if (hopper_ack)                 state_d = ST_GAP;
        else if (timer_q == TIMEOUT_CNT) state_d = ST_FAULT;
      end
      ST_GAP:    if (timer_q == GAP_LAST) state_d = ST_SELECT;
      ST_DONE:   state_d = ST_IDLE;
      ST_FAULT:  if (clr) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    done  = (state_q == ST_DONE);
    fault = (state_q == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      owed_q  <= '0;
      disp_q  <= '0;
      val_q   <= '0;
      eject_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            owed_q <= change_total(change_dollar, change_quarters,
                                   change_dimes, change_nickels);
            disp_q <= '0;
          end
        end
        ST_SELECT: begin
          timer_q <= '0;
          if ((owed_q != 9'd0) && sel_valid) begin
            eject_q <= sel_onehot;
            val_q   <= sel_value;
          end
        end
        ST_EJECT: begin
          if (hopper_ack) begin
            owed_q  <= owed_q - val_q;
            disp_q  <= disp_q + val_q;
            eject_q <= '0;
            timer_q <= '0;
          end else if (timer_q == TIMEOUT_CNT) begin
            eject_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_GAP:   timer_q <= timer_q + 1'b1;
        ST_FAULT: if (clr) owed_q <= '0;
        default: ;
      endcase
    end
  end

  assign eject_req = eject_q;
  assign owed      = owed_q;
  assign dispensed = disp_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a hand-driven hopper model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       change_dollar;
  logic [1:0] change_quarters;
  logic [3:0] change_dimes;
  logic [4:0] change_nickels;
  logic [3:0] hopper_empty;
  logic       hopper_ack;
  logic       clr;
  logic [3:0] eject_req;
  logic       ready;
  logic       done;
  logic       fault;
  logic [8:0] owed;
  logic [8:0] dispensed;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;
  bit saw;

  change_dispenser dut (
    .clk             (clk),
    .rst             (rst),
    .load            (load),
    .change_dollar   (change_dollar),
    .change_quarters (change_quarters),
    .change_dimes    (change_dimes),
    .change_nickels  (change_nickels),
    .hopper_empty    (hopper_empty),
    .hopper_ack      (hopper_ack),
    .clr             (clr),
    .eject_req       (eject_req),
    .ready           (ready),
    .done            (done),
    .fault           (fault),
    .owed            (owed),
    .dispensed       (dispensed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_load(input logic dl, input logic [1:0] ql,
                         input logic [3:0] dml, input logic [4:0] nl);
    change_dollar   = dl;
    change_quarters = ql;
    change_dimes    = dml;
    change_nickels  = nl;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_eject(input string tag, input logic [3:0] exp, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (eject_req == 4'b0 && n < 400);
    check(tag, int'(eject_req), int'(exp));
  endtask

  task automatic ack_coin();
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n, output bit saw_ej);
    n = 0;
    saw_ej = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (eject_req != 4'b0) saw_ej = 1'b1;
    end while (!done && n < 100);
    check(tag, int'(done), 1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; clr = 1'b0; hopper_ack = 1'b0; hopper_empty = 4'b0;
    change_dollar = 1'b0; change_quarters = '0; change_dimes = '0; change_nickels = '0;
    repeat (2) @(negedge clk);
    check("rst_eject", int'(eject_req), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_owed", int'(owed), 0);
    check("rst_disp", int'(dispensed), 0);
    rst = 1'b0;
    @(negedge clk);

    // $1 + 25c + 5c = 130, all hoppers stocked
    do_load(1'b1, 2'd1, 4'd0, 5'd1);
    check("t1_owed_load", int'(owed), 130);
    check("t1_not_ready", int'(ready), 0);
    wait_eject("t1_ej_dollar", 4'b1000, cyc);
    check("t1_latency", cyc, 1);
    ack_coin();
    wait_eject("t1_ej_quarter", 4'b0100, cyc);
    check("t1_spacing1", cyc, 5);
    check("t1_owed_mid", int'(owed), 30);
    ack_coin();
    wait_eject("t1_ej_nickel", 4'b0001, cyc);
    check("t1_spacing2", cyc, 5);
    ack_coin();
    wait_done("t1_done", cyc, saw);
    check("t1_owed_end", int'(owed), 0);
    check("t1_disp_end", int'(dispensed), 130);
    @(negedge clk);
    check("t1_done_pulse", int'(done), 0);
    check("t1_ready_back", int'(ready), 1);

    // Stray ack while idle must not move anything
    ack_coin();
    check("idle_ack_ready", int'(ready), 1);
    check("idle_ack_disp", int'(dispensed), 130);

    // Quarter hopper empty: 25 paid as 10,10,5
    hopper_empty = 4'b0100;
    do_load(1'b0, 2'd1, 4'd0, 5'd0);
    wait_eject("t2_ej_dime1", 4'b0010, cyc);
    ack_coin();
    wait_eject("t2_ej_dime2", 4'b0010, cyc);
    ack_coin();
    wait_eject("t2_ej_nickel", 4'b0001, cyc);
    ack_coin();
    wait_done("t2_done", cyc, saw);
    check("t2_disp", int'(dispensed), 25);
    hopper_empty = 4'b0000;
    @(negedge clk);

    // 20c owed, dime and nickel hoppers empty: fault from SELECT
    hopper_empty = 4'b0011;
    do_load(1'b0, 2'd0, 4'd2, 5'd0);
    @(negedge clk);
    check("t3_fault", int'(fault), 1);
    check("t3_no_eject", int'(eject_req), 0);
    check("t3_owed", int'(owed), 20);
    do_load(1'b0, 2'd0, 4'd0, 5'd1);
    check("t3_load_in_fault", int'(owed), 20);
    check("t3_still_fault", int'(fault), 1);
    hopper_empty = 4'b0000;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t3_clr_ready", int'(ready), 1);
    check("t3_clr_owed", int'(owed), 0);

    // Nickel never acknowledged: jam fault after the timeout window
    do_load(1'b0, 2'd0, 4'd0, 5'd1);
    wait_eject("t4_ej_nickel", 4'b0001, cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fault && cyc < 400);
    check("t4_timeout_cycles", cyc, 256);
    check("t4_fault", int'(fault), 1);
    check("t4_eject_dropped", int'(eject_req), 0);
    check("t4_owed", int'(owed), 5);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t4_clr_ready", int'(ready), 1);
    check("t4_clr_owed", int'(owed), 0);

    // 15c; load pulsed during GAP is ignored; hopper empties mid-eject
    do_load(1'b0, 2'd0, 4'd1, 5'd1);
    wait_eject("t5_ej_dime", 4'b0010, cyc);
    hopper_empty = 4'b0010;
    ack_coin();
    do_load(1'b1, 2'd3, 4'd9, 5'd9);
    hopper_empty = 4'b0000;
    check("t5_gap_owed", int'(owed), 5);
    check("t5_gap_disp", int'(dispensed), 10);
    wait_eject("t5_ej_nickel", 4'b0001, cyc);
    ack_coin();
    wait_done("t5_done", cyc, saw);
    check("t5_disp", int'(dispensed), 15);
    check("t5_owed", int'(owed), 0);
    @(negedge clk);

    // Zero change: done two cycles after load, no eject
    do_load(1'b0, 2'd0, 4'd0, 5'd0);
    wait_done("t6_done", cyc, saw);
    check("t6_latency", cyc, 1);
    check("t6_no_eject", int'(saw), 0);
    @(negedge clk);

    // Asynchronous reset while an eject is pending
    do_load(1'b1, 2'd0, 4'd0, 5'd0);
    wait_eject("t7_ej_dollar", 4'b1000, cyc);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_eject", int'(eject_req), 0);
    check("t7_rst_ready", int'(ready), 1);
    check("t7_rst_owed", int'(owed), 0);
    check("t7_rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t7_post_done", int'(done), 0);
    check("t7_post_ready", int'(ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
